// File: rtl/instr_inv_queue.sv
// Line-invalidation queue for instruction-side consumers: snoops committed stores in the
// instruction range, coalesces repeats, drains line addresses, and falls back to invalidate-all on overflow.
module instr_inv_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] ADDR_L    = 32'h80000000,
   parameter logic [31:0] ADDR_H    = 32'h8FFFFFFF,
   parameter int          LINE_W    = 4,
   localparam int         LINE_BITS = 2 + $clog2(LINE_W),
   localparam int         LW        = 32 - LINE_BITS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          snoop_valid,
   input  logic [31:0]   snoop_addr,
   output logic          inv_valid,
   output logic [LW-1:0] inv_line,
   input  logic          inv_ack,
   output logic          inv_all_valid,
   input  logic          inv_all_ack,
   input  logic          fence_req,
   output logic          fence_done,
   output logic [7:0]    status
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {NORMAL, FLUSH_ALL} state_e;

   state_e        state_q, state_d;
   logic [LW-1:0] mem_q [DEPTH];
   logic [LW-1:0] last_q;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, enq_idx;
   logic [4:0]    cnt_q, cnt_d;
   logic          ovf_q, ovf_d, fpend_q, fpend_d, fdone_q, fdone_d;
   logic          in_rng, pop, enq, coal, pend;
   logic [LW-1:0] snoop_line;

   // Explicit wrap so non-power-of-2 depths go DEPTH-1 -> 0.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign snoop_line = snoop_addr[31:LINE_BITS];
   assign in_rng     = snoop_valid && (snoop_addr >= ADDR_L) && (snoop_addr <= ADDR_H);

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      enq_idx = wr_q;
      pop     = 1'b0;
      enq     = 1'b0;
      coal    = 1'b0;
      case (state_q)
         NORMAL: begin
            pop = (cnt_q != 5'd0) && inv_ack;
            if (in_rng) begin
               coal = (cnt_q != 5'd0) && (snoop_line == last_q);
               if (!coal) begin
                  if ((cnt_q < 5'(DEPTH)) || pop) begin
                     enq = 1'b1;
                  end else begin
                     ovf_d   = 1'b1;
                     state_d = FLUSH_ALL;
                  end
               end
            end
            if (pop) rd_d = ptr_inc(rd_q);
            if (enq) wr_d = ptr_inc(wr_q);
            if (enq && !pop)      cnt_d = cnt_q + 5'd1;
            else if (!enq && pop) cnt_d = cnt_q - 5'd1;
         end
         FLUSH_ALL: begin
            // The invalidate-all covers everything queued; a snoop in the ack cycle starts a fresh queue.
            if (inv_all_ack) begin
               state_d = NORMAL;
               ovf_d   = 1'b0;
               rd_d    = '0;
               enq_idx = '0;
               enq     = in_rng;
               wr_d    = in_rng ? ptr_inc('0) : '0;
               cnt_d   = {4'd0, in_rng};
            end
         end
         default: state_d = NORMAL;
      endcase
      pend    = fpend_q || fence_req;
      fdone_d = pend && (state_d == NORMAL) && (cnt_d == 5'd0);
      fpend_d = pend && !fdone_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= NORMAL;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         fpend_q <= 1'b0;
         fdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         fpend_q <= fpend_d;
         fdone_q <= fdone_d;
      end
   end

   // Payload storage needs no reset; last_q is only consulted while the queue is non-empty.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_q[enq_idx] <= snoop_line;
         last_q         <= snoop_line;
      end
   end

   assign inv_valid     = (state_q == NORMAL) && (cnt_q != 5'd0);
   assign inv_line      = mem_q[rd_q];
   assign inv_all_valid = (state_q == FLUSH_ALL);
   assign fence_done    = fdone_q;
   assign status        = {ovf_q, fpend_q, 1'b0, cnt_q};

endmodule
